seq_detect_param: RTL and testbench

//   Parametrised serial pattern detector, successor to the fixed-pattern Moore

---
 rtl/seq_detect_param.sv | 73 +++++++
 tb/tb_seq_detect_param.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Serial pattern detector: loadable PAT_LEN-bit pattern, overlap/non-overlap mode, saturating match counter.
// Latency: seq_out is registered and pulses for one cycle starting at the edge that samples the final pattern bit.
// Backpressure: none; seq_en=0 stalls the history, and pat_load discards it and restarts matching.
module seq_detect_param #(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PATTERN = 4'b1110,
   parameter bit                 OVERLAP = 1'b1,
   parameter int                 CNT_W   = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               seq_in,
   input  logic               seq_en,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
   input  logic               cnt_clr,
   output logic               seq_out,
   output logic [CNT_W-1:0]   match_count
);

   localparam int                FILL_W    = $clog2(PAT_LEN + 1);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_LEN);
   localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

   logic [PAT_LEN-1:0] pat;
   logic [PAT_LEN-1:0] hist;
   logic [PAT_LEN-1:0] hist_n;
   logic [FILL_W-1:0]  fill;
   logic [FILL_W-1:0]  fill_n;
   logic               match;

   // Candidate history after shifting in the current bit, and whether it completes a match.
   // A load on this edge suppresses any match; stale bits never match until the history is full.
   always_comb begin
      hist_n = {hist[PAT_LEN-2:0], seq_in};
      fill_n = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      match  = !pat_load && seq_en && (hist_n == pat) && (fill_n == FILL_FULL);
   end

   // Pattern register, shift history, fill level and the registered match pulse.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pat     <= PATTERN;
         hist    <= '0;
         fill    <= '0;
         seq_out <= 1'b0;
      end else if (pat_load) begin
         pat     <= pat_in;
         hist    <= '0;
         fill    <= '0;
         seq_out <= 1'b0;
      end else if (seq_en) begin
         hist    <= hist_n;
         seq_out <= match;
         // Non-overlap mode forgets everything after a match so bits cannot be reused.
         fill    <= (match && !OVERLAP) ? '0 : fill_n;
      end else begin
         seq_out <= 1'b0;
      end
   end

   // Saturating match counter; a clear wins over a simultaneous match.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         match_count <= '0;
      end else if (cnt_clr) begin
         match_count <= '0;
      end else if (match && (match_count != CNT_MAX)) begin
         match_count <= match_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three instances (overlap/8-bit count, non-overlap, overlap/2-bit count)
// share one stimulus stream and are compared every cycle against a stream-level reference model.
module tb_seq_detect_param;

   logic       clock;
   logic       reset;
   logic       seq_in;
   logic       seq_en;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       cnt_clr;

   logic       so_a, so_b, so_c;
   logic [7:0] mc_a, mc_b;
   logic [1:0] mc_c;

   logic       so [3];
   logic [7:0] mc [3];

   seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1110), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
      .clock(clock), .reset(reset), .seq_in(seq_in), .seq_en(seq_en), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .seq_out(so_a), .match_count(mc_a));
   seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1110), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
      .clock(clock), .reset(reset), .seq_in(seq_in), .seq_en(seq_en), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .seq_out(so_b), .match_count(mc_b));
   seq_detect_param #(.PAT_LEN(4), .PATTERN(4'b1110), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
      .clock(clock), .reset(reset), .seq_in(seq_in), .seq_en(seq_en), .pat_load(pat_load),
      .pat_in(pat_in), .cnt_clr(cnt_clr), .seq_out(so_c), .match_count(mc_c));

   assign so[0] = so_a;
   assign so[1] = so_b;
   assign so[2] = so_c;
   assign mc[0] = mc_a;
   assign mc[1] = mc_b;
   assign mc[2] = {6'b0, mc_c};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Reference model: the full stream of accepted bits, and for each instance the
   // stream index where its usable history starts (moved by reset, load, non-overlap match).
   bit         stream [$];
   int         start [3];
   logic [3:0] exp_pat;
   logic       exp_so [3];
   logic [7:0] exp_mc [3];
   int         cmax [3] = '{255, 255, 3};
   bit         ovl  [3] = '{1'b1, 1'b0, 1'b1};

   function automatic bit tail_is_pat(int k);
      int n;
      n = stream.size();
      if (n - start[k] < 4) return 1'b0;
      for (int i = 0; i < 4; i++)
         if (stream[n-1-i] != exp_pat[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      exp_pat = 4'b1110;
      for (int k = 0; k < 3; k++) begin
         start[k]  = stream.size();
         exp_so[k] = 1'b0;
         exp_mc[k] = 8'd0;
      end
   endtask

   task automatic model_edge();
      bit m;
      if (!pat_load && seq_en) stream.push_back(seq_in);
      for (int k = 0; k < 3; k++) begin
         m = 1'b0;
         if (pat_load) begin
            start[k]  = stream.size();
            exp_so[k] = 1'b0;
         end else if (seq_en) begin
            m         = tail_is_pat(k);
            exp_so[k] = m;
            if (m && !ovl[k]) start[k] = stream.size();
         end else begin
            exp_so[k] = 1'b0;
         end
         if (cnt_clr) exp_mc[k] = 8'd0;
         else if (m && (int'(exp_mc[k]) < cmax[k])) exp_mc[k] = exp_mc[k] + 8'd1;
      end
      if (pat_load) exp_pat = pat_in;
   endtask

   task automatic tick(input bit b, input bit en, input bit ld, input logic [3:0] p, input bit clr);
      seq_in   = b;
      seq_en   = en;
      pat_load = ld;
      pat_in   = p;
      cnt_clr  = clr;
      @(posedge clock);
      model_edge();
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      seq_in = 0; seq_en = 0; pat_load = 0; pat_in = 4'b0000; cnt_clr = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b1;
      #1;
      model_reset();
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (so[k] !== 1'b0) begin errors++; $display("FAIL reset_seq_out[%0d]: got %b expected 0", k, so[k]); end
         checks++;
         if (mc[k] !== 8'd0) begin errors++; $display("FAIL reset_count[%0d]: got %0d expected 0", k, mc[k]); end
      end
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_default_pattern();
      bit bits [5] = '{0, 1, 1, 1, 0};
      for (int i = 0; i < 5; i++) begin
         tick(bits[i], 1, 0, 4'b0000, 0);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL default_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
            checks++;
            if (mc[k] !== exp_mc[k]) begin errors++; $display("FAIL default_count[%0d] bit %0d: got %0d expected %0d", k, i, mc[k], exp_mc[k]); end
         end
      end
      checks++;
      if (so[0] !== 1'b1 || mc[0] !== 8'd1) begin
         errors++; $display("FAIL default_final: got seq_out=%b count=%0d expected 1/1", so[0], mc[0]);
      end
   endtask

   task automatic test_overlap_mode();
      bit bits [6] = '{1, 0, 1, 0, 1, 0};
      int pulses [3] = '{0, 0, 0};
      tick(0, 0, 1, 4'b1010, 1);
      for (int i = 0; i < 6; i++) begin
         tick(bits[i], 1, 0, 4'b0000, 0);
         for (int k = 0; k < 3; k++) begin
            pulses[k] += int'(so[k]);
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL overlap_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
            checks++;
            if (mc[k] !== exp_mc[k]) begin errors++; $display("FAIL overlap_count[%0d] bit %0d: got %0d expected %0d", k, i, mc[k], exp_mc[k]); end
         end
      end
      checks++;
      if (pulses[0] != 2 || pulses[1] != 1 || mc[0] !== 8'd2 || mc[1] !== 8'd1) begin
         errors++; $display("FAIL overlap_totals: got pulses %0d/%0d counts %0d/%0d expected 2/1 2/1", pulses[0], pulses[1], mc[0], mc[1]);
      end
   endtask

   task automatic test_enable_gaps();
      bit bits [4] = '{1, 1, 1, 0};
      int pulses = 0;
      tick(0, 0, 1, 4'b1110, 1);
      for (int i = 0; i < 4; i++) begin
         for (int g = 0; g < 4; g++) begin
            if (g == 0) tick(bits[i], 1, 0, 4'b0000, 0);
            else        tick(~bits[i], 0, 0, 4'b0000, 0);
            pulses += int'(so[0]);
            if (g != 0) begin
               checks++;
               if (so[0] !== 1'b0) begin errors++; $display("FAIL gap_seq_out bit %0d gap %0d: got %b expected 0", i, g, so[0]); end
            end
            for (int k = 0; k < 3; k++) begin
               checks++;
               if (so[k] !== exp_so[k]) begin errors++; $display("FAIL gap_model_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
            end
         end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL gap_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_reset_mid_pattern();
      bit bits [4] = '{1, 1, 1, 0};
      int pulses = 0;
      for (int i = 0; i < 3; i++) tick(1, 1, 0, 4'b0000, 0);
      reset = 1'b1;
      #1;
      model_reset();
      @(negedge clock);
      reset = 1'b0;
      tick(0, 1, 0, 4'b0000, 0);
      checks++;
      if (so[0] !== 1'b0) begin errors++; $display("FAIL rstmid_no_pulse: got %b expected 0", so[0]); end
      for (int i = 0; i < 4; i++) begin
         tick(bits[i], 1, 0, 4'b0000, 0);
         pulses += int'(so[0]);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL rstmid_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
            checks++;
            if (mc[k] !== exp_mc[k]) begin errors++; $display("FAIL rstmid_count[%0d] bit %0d: got %0d expected %0d", k, i, mc[k], exp_mc[k]); end
         end
      end
      checks++;
      if (pulses != 1) begin errors++; $display("FAIL rstmid_pulses: got %0d expected 1", pulses); end
   endtask

   task automatic test_saturate_back_to_back();
      int pulses [3] = '{0, 0, 0};
      tick(0, 0, 1, 4'b1111, 1);
      for (int i = 0; i < 12; i++) begin
         tick(1, 1, 0, 4'b0000, 0);
         for (int k = 0; k < 3; k++) begin
            pulses[k] += int'(so[k]);
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL sat_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
            checks++;
            if (mc[k] !== exp_mc[k]) begin errors++; $display("FAIL sat_count[%0d] bit %0d: got %0d expected %0d", k, i, mc[k], exp_mc[k]); end
         end
      end
      checks++;
      if (pulses[0] != 9 || pulses[2] != 9 || pulses[1] != 3 || mc[2] !== 8'd3) begin
         errors++; $display("FAIL sat_totals: got pulses %0d/%0d/%0d count_c %0d expected 9/3/9 3", pulses[0], pulses[1], pulses[2], mc[2]);
      end
      tick(1, 1, 0, 4'b0000, 1);
      checks++;
      if (so[0] !== 1'b1 || mc[0] !== 8'd0 || mc[2] !== 8'd0) begin
         errors++; $display("FAIL sat_clear_on_match: got seq_out=%b counts %0d/%0d expected 1 0/0", so[0], mc[0], mc[2]);
      end
   endtask

   task automatic test_load_collision();
      bit bits [4] = '{0, 1, 0, 1};
      int pulses = 0;
      tick(0, 0, 1, 4'b1110, 1);
      for (int i = 0; i < 3; i++) tick(1, 1, 0, 4'b0000, 0);
      tick(0, 1, 1, 4'b0101, 0);
      checks++;
      if (so[0] !== 1'b0 || mc[0] !== 8'd0) begin
         errors++; $display("FAIL load_collision: got seq_out=%b count=%0d expected 0/0", so[0], mc[0]);
      end
      for (int i = 0; i < 4; i++) begin
         tick(bits[i], 1, 0, 4'b0000, 0);
         pulses += int'(so[0]);
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL load_seq_out[%0d] bit %0d: got %b expected %b", k, i, so[k], exp_so[k]); end
         end
      end
      checks++;
      if (pulses != 1 || so[0] !== 1'b1) begin errors++; $display("FAIL load_restart: got pulses %0d last %b expected 1 1", pulses, so[0]); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 24) == 0),
              4'($urandom), ($urandom_range(0, 39) == 0));
         for (int k = 0; k < 3; k++) begin
            checks++;
            if (so[k] !== exp_so[k]) begin errors++; $display("FAIL rand_seq_out[%0d] cyc %0d: got %b expected %b", k, cyc, so[k], exp_so[k]); end
            checks++;
            if (mc[k] !== exp_mc[k]) begin errors++; $display("FAIL rand_count[%0d] cyc %0d: got %0d expected %0d", k, cyc, mc[k], exp_mc[k]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_default_pattern();
      test_overlap_mode();
      test_enable_gaps();
      test_reset_mid_pattern();
      test_saturate_back_to_back();
      test_load_collision();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
